multi_accum_looper: RTL and testbench
=====================================

MULTI_ACCUM_LOOPER -- requirements
Module: multi_accum_looper

Interface
REQ-001 Parameter N_DST, default 3: number of broadcast destinations.
REQ-002 Parameter DIM, default TauCfg::DIM: number of loop dimensions.
REQ-003 Parameter WBW, default TauCfg::WORK_BW: offset width.
REQ-004 Parameters AF_BW and AS_BW, default TauCfg::AOFS_FRAC_BW and TauCfg::AOFS_SHAMT_BW: step fraction and shift widths.
REQ-005 Port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port src_rdy, input, 1 bit: block config valid; all i_* config held stable while high.
REQ-008 Port src_ack, output, 1 bit: one-cycle pulse, block fully consumed.
REQ-009 Ports i_bofs, i_agrid_frac, i_agrid_shamt, i_agrid_last, i_aboundary, i_alocal_last, input, [DIM] arrays of WBW/AF_BW/AS_BW/WBW/WBW/WBW bits: block offset, step fraction, step shift, inclusive grid last, clamp boundary, local span.
REQ-010 Port i_dst_en, input, N_DST bits: per-destination enable, sampled at block start.
REQ-011 Ports dst_rdy (output) and dst_ack (input), N_DST bits each: per-destination handshake.
REQ-012 Ports o_bofs, o_aofs, o_alast, output, [DIM] x WBW: shared payload for all destinations.
REQ-013 Port blkdone_dval, output, 1 bit: pulse on the last tuple's completion.

Function
REQ-014 Per-dimension step = i_agrid_frac[d] << i_agrid_shamt[d], computed at WBW bits.
REQ-015 States: IDLE, LOAD, BCAST.
REQ-016 IDLE -> LOAD when src_rdy=1; LOAD latches i_dst_en into en_q, clears aofs to 0, clears done bits.
REQ-017 LOAD -> BCAST next cycle; dst_rdy[k] = en_q[k] & ~done[k] in BCAST only.
REQ-018 Handshake completes for k in a cycle with dst_rdy[k]&dst_ack[k]; done[k] is set; payload is held until all enabled destinations are done.
REQ-019 A tuple completes in the cycle the remaining enabled destinations ack; simultaneous acks from several destinations in one cycle are legal.
REQ-020 On tuple completion: done is cleared and aofs is advanced as an odometer, dimension DIM-1 innermost.
REQ-021 A dimension advances to aofs+step if that value, computed at WBW+1 bits, is <= i_agrid_last[d]; otherwise it wraps to 0 and carries to d-1.
REQ-022 step=0 means a single iteration for that dimension.
REQ-023 The last tuple is the one where every dimension wraps; its completion pulses src_ack and blkdone_dval in the same cycle; the FSM goes to IDLE.
REQ-024 i_dst_en=0 (all disabled): BCAST is skipped, all tuples are iterated internally one per cycle, and src_ack/blkdone pulse on the last tuple.
REQ-025 o_bofs = i_bofs; o_aofs = registered aofs.
REQ-026 o_alast[d] = min(aofs[d]+i_alocal_last[d], i_aboundary[d]); the sum is computed at WBW+1 bits, and a carry counts as > boundary.
REQ-027 A new block is not accepted in the src_ack cycle; earliest LOAD is the following cycle.

Reset
REQ-028 i_rst=1 forces IDLE and clears aofs, done and en_q; src_ack, dst_rdy, blkdone_dval are 0 the next cycle, including mid-block.
REQ-029 The block in progress at reset is discarded without a src_ack.

Structure
REQ-030 Offset width, DIM and step widths come from the TauCfg package; the FSM state enum is placed in TauCfg.
REQ-031 Per-dimension step/compare/wrap logic sits in one sub-module, accum_odometer; the handshake FSM and done bits live in the top.

Verification
REQ-032 DIM=2, last={2,1}, frac=1, shamt=0, all acks tied 1, en=3'b111 -> 6 tuples (0,0),(0,1),(1,0),(1,1),(2,0),(2,1), one per cycle; src_ack and blkdone on the 6th.
REQ-033 Same config, dst_ack[1] delayed 3 cycles per tuple -> payload held; each tuple takes 4 cycles; dst0/dst2 rdy drop after their own ack.
REQ-034 en=3'b010 -> only dst_rdy[1] is ever asserted; en=3'b000 -> src_ack after 6 internal cycles, no dst_rdy.
REQ-035 frac=3, shamt=1, last=7 (DIM=1) -> aofs 0,6 then wrap; local_last=5, boundary=8 -> o_alast 5, 8.
REQ-036 WBW=8, aofs=250, step=10, last=255 -> carry detected, wraps to 0, block ends.
REQ-037 i_rst asserted during the 3rd tuple -> all outputs 0 next cycle, no src_ack; a fresh block restarts at aofs=0.

Source files
------------

// File: rtl/multi_accum_looper_pkg.sv
// rtl/multi_accum_looper_pkg.sv - shared widths, loop dimensions and looper FSM states
package TauCfg;
  localparam int DIM           = 2;
  localparam int WORK_BW       = 8;
  localparam int AOFS_FRAC_BW  = 4;
  localparam int AOFS_SHAMT_BW = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BCAST
  } looper_state_e;
endpackage

// File: rtl/multi_accum_looper_odometer.sv
// rtl/multi_accum_looper_odometer.sv - per-dimension step/compare/wrap, innermost dimension DIM-1
module accum_odometer
  import TauCfg::*;
#(
  parameter int DIM   = TauCfg::DIM,
  parameter int WBW   = TauCfg::WORK_BW,
  parameter int AF_BW = TauCfg::AOFS_FRAC_BW,
  parameter int AS_BW = TauCfg::AOFS_SHAMT_BW
) (
  input  logic [WBW-1:0]   aofs          [DIM],
  input  logic [AF_BW-1:0] agrid_frac    [DIM],
  input  logic [AS_BW-1:0] agrid_shamt   [DIM],
  input  logic [WBW-1:0]   agrid_last    [DIM],
  output logic [WBW-1:0]   aofs_nxt      [DIM],
  output logic             wrap_all
);
  always_comb begin
    logic           carry;
    logic [WBW-1:0] step;
    logic [WBW:0]   sum;
    carry = 1'b1;
    step  = '0;
    sum   = '0;
    for (int d = DIM - 1; d >= 0; d--) begin
      step        = WBW'(agrid_frac[d]) << agrid_shamt[d];
      sum         = {1'b0, aofs[d]} + {1'b0, step};
      aofs_nxt[d] = aofs[d];
      if (carry) begin
        // A zero step would never leave 0, so it is treated as a one-pass dimension.
        if (step != '0 && sum <= {1'b0, agrid_last[d]}) begin
          aofs_nxt[d] = sum[WBW-1:0];
          carry       = 1'b0;
        end else begin
          aofs_nxt[d] = '0;
        end
      end
    end
    wrap_all = carry;
  end
endmodule

// File: rtl/multi_accum_looper.sv
// rtl/multi_accum_looper.sv - iterates a multi-dimensional offset grid and broadcasts each tuple
module multi_accum_looper
  import TauCfg::*;
#(
  parameter int N_DST = 3,
  parameter int DIM   = TauCfg::DIM,
  parameter int WBW   = TauCfg::WORK_BW,
  parameter int AF_BW = TauCfg::AOFS_FRAC_BW,
  parameter int AS_BW = TauCfg::AOFS_SHAMT_BW
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             src_rdy,
  output logic             src_ack,
  input  logic [WBW-1:0]   i_bofs        [DIM],
  input  logic [AF_BW-1:0] i_agrid_frac  [DIM],
  input  logic [AS_BW-1:0] i_agrid_shamt [DIM],
  input  logic [WBW-1:0]   i_agrid_last  [DIM],
  input  logic [WBW-1:0]   i_aboundary   [DIM],
  input  logic [WBW-1:0]   i_alocal_last [DIM],
  input  logic [N_DST-1:0] i_dst_en,
  output logic [N_DST-1:0] dst_rdy,
  input  logic [N_DST-1:0] dst_ack,
  output logic [WBW-1:0]   o_bofs        [DIM],
  output logic [WBW-1:0]   o_aofs        [DIM],
  output logic [WBW-1:0]   o_alast       [DIM],
  output logic             blkdone_dval
);
  looper_state_e  state;
  logic [N_DST-1:0] en_q;
  logic [N_DST-1:0] done;
  logic [WBW-1:0]   aofs     [DIM];
  logic [WBW-1:0]   aofs_nxt [DIM];
  logic             wrap_all;
  logic             tuple_done;
  logic             blk_last;

  accum_odometer #(
    .DIM   (DIM),
    .WBW   (WBW),
    .AF_BW (AF_BW),
    .AS_BW (AS_BW)
  ) u_odometer (
    .aofs        (aofs),
    .agrid_frac  (i_agrid_frac),
    .agrid_shamt (i_agrid_shamt),
    .agrid_last  (i_agrid_last),
    .aofs_nxt    (aofs_nxt),
    .wrap_all    (wrap_all)
  );

  assign dst_rdy      = (state == ST_BCAST) ? (en_q & ~done) : '0;
  // With no destinations enabled the pending set is empty, so tuples retire one per cycle.
  assign tuple_done   = (state == ST_BCAST) && ((en_q & ~done & ~dst_ack) == '0);
  assign blk_last     = tuple_done && wrap_all;
  assign src_ack      = blk_last;
  assign blkdone_dval = blk_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      en_q  <= '0;
      done  <= '0;
      for (int d = 0; d < DIM; d++) aofs[d] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (src_rdy) state <= ST_LOAD;
        end
        ST_LOAD: begin
          en_q  <= i_dst_en;
          done  <= '0;
          for (int d = 0; d < DIM; d++) aofs[d] <= '0;
          state <= ST_BCAST;
        end
        ST_BCAST: begin
          if (tuple_done) begin
            done <= '0;
            for (int d = 0; d < DIM; d++) aofs[d] <= aofs_nxt[d];
            if (wrap_all) state <= ST_IDLE;
          end else begin
            done <= done | (dst_rdy & dst_ack);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    logic [WBW:0] sum;
    sum = '0;
    for (int d = 0; d < DIM; d++) begin
      o_bofs[d] = i_bofs[d];
      o_aofs[d] = aofs[d];
      // The extra sum bit makes an overflowing span compare above any boundary.
      sum = {1'b0, aofs[d]} + {1'b0, i_alocal_last[d]};
      o_alast[d] = (sum > {1'b0, i_aboundary[d]}) ? i_aboundary[d] : sum[WBW-1:0];
    end
  end
endmodule

// File: tb/tb_multi_accum_looper.sv
// tb/tb_multi_accum_looper.sv - randomized self-checking bench for multi_accum_looper
module tb_multi_accum_looper;
  import TauCfg::*;

  localparam int N_DST = 3;
  localparam int D     = TauCfg::DIM;
  localparam int W     = TauCfg::WORK_BW;
  localparam int FBW   = TauCfg::AOFS_FRAC_BW;
  localparam int SBW   = TauCfg::AOFS_SHAMT_BW;

  logic             i_clk;
  logic             i_rst;
  logic             src_rdy;
  logic             src_ack;
  logic [W-1:0]     bofs  [D];
  logic [FBW-1:0]   frac  [D];
  logic [SBW-1:0]   shamt [D];
  logic [W-1:0]     glast [D];
  logic [W-1:0]     bnd   [D];
  logic [W-1:0]     loc   [D];
  logic [N_DST-1:0] dst_en;
  logic [N_DST-1:0] dst_rdy;
  logic [N_DST-1:0] dst_ack;
  logic [W-1:0]     o_bofs  [D];
  logic [W-1:0]     o_aofs  [D];
  logic [W-1:0]     o_alast [D];
  logic             blkdone_dval;

  int n_checks;
  int n_fail;
  int q0[$];
  int q1[$];

  multi_accum_looper #(.N_DST(N_DST)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .src_rdy       (src_rdy),
    .src_ack       (src_ack),
    .i_bofs        (bofs),
    .i_agrid_frac  (frac),
    .i_agrid_shamt (shamt),
    .i_agrid_last  (glast),
    .i_aboundary   (bnd),
    .i_alocal_last (loc),
    .i_dst_en      (dst_en),
    .dst_rdy       (dst_rdy),
    .dst_ack       (dst_ack),
    .o_bofs        (o_bofs),
    .o_aofs        (o_aofs),
    .o_alast       (o_alast),
    .blkdone_dval  (blkdone_dval)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int step_of(input int d);
    return (int'(frac[d]) << int'(shamt[d])) & ((1 << W) - 1);
  endfunction

  // Expected tuple sequence: each dimension visits 0, step, 2*step ... up to its inclusive last.
  task automatic build_model();
    int s0, s1;
    q0.delete();
    q1.delete();
    s0 = step_of(0);
    s1 = step_of(1);
    for (int x = 0; x <= int'(glast[0]); x += s0) begin
      for (int y = 0; y <= int'(glast[1]); y += s1) begin
        q0.push_back(x);
        q1.push_back(y);
        if (s1 == 0) break;
      end
      if (s0 == 0) break;
    end
  endtask

  function automatic int exp_alast(input int a, input int d);
    int s;
    s = a + int'(loc[d]);
    return (s > int'(bnd[d])) ? int'(bnd[d]) : s;
  endfunction

  task automatic set_cfg(input int l0, input int l1, input int f0, input int f1,
                         input int sh0, input int sh1);
    glast[0] = W'(l0);  glast[1] = W'(l1);
    frac[0]  = FBW'(f0); frac[1]  = FBW'(f1);
    shamt[0] = SBW'(sh0); shamt[1] = SBW'(sh1);
    for (int d = 0; d < D; d++) begin
      bofs[d] = W'($urandom);
      loc[d]  = W'($urandom);
      bnd[d]  = W'($urandom);
    end
  endtask

  task automatic run_block(input logic [N_DST-1:0] en, input int ack_mode, input int rst_at);
    logic [N_DST-1:0] pend;
    logic             cmpl, last;
    int               idx, cyc, total;
    build_model();
    total  = q0.size();
    dst_en = en;
    @(negedge i_clk);
    src_rdy = 1'b1;
    @(negedge i_clk);
    check_eq("load_rdy", 32'(dst_rdy), 0);
    pend = en;
    idx  = 0;
    cyc  = 0;
    while (idx < total && cyc < 5000) begin
      @(negedge i_clk);
      cyc++;
      if (idx == rst_at) begin
        i_rst   = 1'b1;
        dst_ack = '0;
        @(negedge i_clk);
        i_rst   = 1'b0;
        src_rdy = 1'b0;
        check_eq("rst_rdy", 32'(dst_rdy), 0);
        check_eq("rst_ack", 32'(src_ack), 0);
        check_eq("rst_blkdone", 32'(blkdone_dval), 0);
        check_eq("rst_aofs0", 32'(o_aofs[0]), 0);
        check_eq("rst_aofs1", 32'(o_aofs[1]), 0);
        @(negedge i_clk);
        check_eq("post_rst_ack", 32'(src_ack), 0);
        return;
      end
      check_eq("dst_rdy", 32'(dst_rdy), 32'(pend));
      check_eq("aofs0", 32'(o_aofs[0]), q0[idx]);
      check_eq("aofs1", 32'(o_aofs[1]), q1[idx]);
      check_eq("alast0", 32'(o_alast[0]), exp_alast(q0[idx], 0));
      check_eq("alast1", 32'(o_alast[1]), exp_alast(q1[idx], 1));
      check_eq("bofs0", 32'(o_bofs[0]), 32'(bofs[0]));
      dst_ack = (ack_mode == 0) ? '1 : N_DST'($urandom);
      #1;
      cmpl = ((pend & ~dst_ack) == '0);
      last = cmpl && (idx == total - 1);
      check_eq("src_ack", 32'(src_ack), 32'(last));
      check_eq("blkdone", 32'(blkdone_dval), 32'(last));
      if (cmpl) begin
        idx++;
        pend = en;
      end else begin
        pend = pend & ~dst_ack;
      end
    end
    if (idx < total) check_eq("block_timeout", 32'(idx), 32'(total));
    @(negedge i_clk);
    src_rdy = 1'b0;
    dst_ack = '0;
    check_eq("idle_rdy", 32'(dst_rdy), 0);
    check_eq("idle_ack", 32'(src_ack), 0);
    @(negedge i_clk);
    check_eq("idle_rdy2", 32'(dst_rdy), 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    i_rst    = 1'b1;
    src_rdy  = 1'b0;
    dst_ack  = '0;
    dst_en   = '0;
    set_cfg(2, 1, 1, 1, 0, 0);
    repeat (2) @(negedge i_clk);
    check_eq("reset_rdy", 32'(dst_rdy), 0);
    check_eq("reset_ack", 32'(src_ack), 0);
    check_eq("reset_aofs0", 32'(o_aofs[0]), 0);
    i_rst = 1'b0;

    set_cfg(2, 1, 1, 1, 0, 0);
    run_block(3'b111, 0, -1);
    run_block(3'b111, 1, -1);
    run_block(3'b010, 1, -1);
    run_block(3'b000, 1, -1);
    set_cfg(7, 0, 3, 0, 1, 0);
    loc[0] = 8'd5;
    bnd[0] = 8'd8;
    run_block(3'b101, 1, -1);
    set_cfg(255, 3, 5, 0, 1, 0);
    loc[0] = 8'd200;
    bnd[0] = 8'd255;
    run_block(3'b111, 0, -1);
    set_cfg(2, 1, 1, 1, 0, 0);
    run_block(3'b111, 1, 2);
    run_block(3'b111, 0, -1);
    for (int b = 0; b < 8; b++) begin
      set_cfg($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
      run_block(N_DST'($urandom), 1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
